// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad matrix scanner.
//   scan_state_t      - FSM state encoding, 3 bits, exported on scan_state
//   row_enc_t         - result of the row priority encoder (index + multi flag)
//   lowest_set_index  - priority encoder over up to MAX_LINES row bits
package keypad_pkg;

  localparam int MAX_LINES = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN       = 3'd1,
    DEBOUNCE_P = 3'd2,
    HELD       = 3'd3,
    DEBOUNCE_R = 3'd4
  } scan_state_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       multi;
  } row_enc_t;

  // Lowest set bit wins; multi flags that more than one bit was set.
  function automatic row_enc_t lowest_set_index(input logic [MAX_LINES-1:0] rows);
    row_enc_t enc;
    int       ones;
    enc.idx   = '0;
    enc.multi = 1'b0;
    ones      = 0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (rows[i]) begin
        enc.idx = 3'(i);
        ones    = ones + 1;
      end
    end
    enc.multi = (ones > 1);
    return enc;
  endfunction

endpackage

// File: rtl/keypad_event_reg.sv
// keypad_event_reg: single-entry valid/ready output register for key events.
// Ports:
//   clock, reset       - clock, asynchronous active-high reset
//   load               - an event is offered this cycle
//   load_code/press    - the offered event
//   key_ready          - consumer ready
//   key_code/key_press - held event
//   key_valid          - an event is held
//   overflow           - sticky: an offered event was dropped
// Handshake: an event transfers on a cycle where key_valid & key_ready; the
// register then empties unless a new event loads in that same cycle.
module keypad_event_reg #(
  parameter int CODE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [CODE_W-1:0] load_code,
  input  logic              load_press,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_press,
  output logic              key_valid,
  output logic              overflow
);

  logic fire;
  assign fire = key_valid & key_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code  <= '0;
      key_press <= 1'b0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load && (!key_valid || fire)) begin
        key_code  <= load_code;
        key_press <= load_press;
        key_valid <= 1'b1;
      end else if (fire) begin
        key_valid <= 1'b0;
      end
      // Full and not draining: the new event is lost, the held one stays.
      if (load && key_valid && !fire) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a ROWS x COLS switch matrix one column at a
// time, debounces presses and releases, and delivers key events through a
// single-entry valid/ready register.
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   row_in         - raw row returns (asynchronous)
//   col_out        - column drive (all ones while idle, one-hot while scanning)
//   key_code       - row_idx*COLS + col_idx of the held event
//   key_press      - 1 press, 0 release
//   key_valid      - event held; key_ready accepts it
//   overflow       - sticky dropped-event flag
//   multi_key      - more than one row active in the latest sample
//   scan_state     - FSM state for debug
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 8,
  parameter int DEBOUNCE = 4,
  localparam int CODE_W  = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_press,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow,
  output logic              multi_key,
  output logic [2:0]        scan_state
);

  localparam int COL_W = $clog2(COLS);
  localparam int DW_W  = $clog2(DWELL);

  scan_state_t      state, state_next;
  logic [ROWS-1:0]  rows_m, rows_s;
  logic [DW_W-1:0]  dwell_cnt;
  logic             sample;
  logic [COL_W-1:0] col_idx, col_next;
  logic [ROWS-1:0]  lat_rows, lat_rows_next;
  logic [2:0]       lat_row, lat_row_next;
  logic [3:0]       deb_cnt, deb_next;
  logic             ev_load, ev_press;
  logic [CODE_W-1:0] ev_code;
  row_enc_t         enc_s;

  assign enc_s   = lowest_set_index(8'(rows_s));
  assign sample  = (dwell_cnt == DW_W'(DWELL - 1));
  assign ev_code = CODE_W'(int'(lat_row) * COLS + int'(col_idx));

  // Synchroniser, dwell counter and sample-time flags. The column drive only
  // changes on a sample cycle, where the counter wraps to 0 anyway, so a
  // free-running wrap restarts the dwell on every column change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rows_m    <= '0;
      rows_s    <= '0;
      dwell_cnt <= '0;
      multi_key <= 1'b0;
    end else begin
      rows_m <= row_in;
      rows_s <= rows_m;
      if (sample) begin
        dwell_cnt <= '0;
        multi_key <= enc_s.multi;
      end else begin
        dwell_cnt <= dwell_cnt + DW_W'(1);
      end
    end
  end

  // FSM state register (with its datapath registers).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      col_idx  <= '0;
      lat_rows <= '0;
      lat_row  <= '0;
      deb_cnt  <= '0;
    end else begin
      state    <= state_next;
      col_idx  <= col_next;
      lat_rows <= lat_rows_next;
      lat_row  <= lat_row_next;
      deb_cnt  <= deb_next;
    end
  end

  // FSM next-state logic; decisions are taken only on sample cycles.
  always_comb begin
    state_next    = state;
    col_next      = col_idx;
    lat_rows_next = lat_rows;
    lat_row_next  = lat_row;
    deb_next      = deb_cnt;
    ev_load       = 1'b0;
    ev_press      = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          if (rows_s != '0) begin
            state_next = SCAN;
            col_next   = '0;
          end
        end
        SCAN: begin
          if (rows_s != '0) begin
            lat_rows_next = rows_s;
            lat_row_next  = enc_s.idx;
            deb_next      = '0;
            state_next    = DEBOUNCE_P;
          end else if (col_idx == COL_W'(COLS - 1)) begin
            // Nothing found in any column: a glitch, no event.
            col_next   = '0;
            state_next = IDLE;
          end else begin
            col_next = col_idx + COL_W'(1);
          end
        end
        DEBOUNCE_P: begin
          if (rows_s == lat_rows) begin
            if (deb_cnt + 4'd1 == 4'(DEBOUNCE)) begin
              ev_load    = 1'b1;
              ev_press   = 1'b1;
              deb_next   = '0;
              state_next = HELD;
            end else begin
              deb_next = deb_cnt + 4'd1;
            end
          end else begin
            col_next   = '0;
            state_next = IDLE;
          end
        end
        HELD: begin
          if (rows_s == '0) begin
            deb_next   = '0;
            state_next = DEBOUNCE_R;
          end
        end
        DEBOUNCE_R: begin
          if (rows_s == '0) begin
            if (deb_cnt + 4'd1 == 4'(DEBOUNCE)) begin
              ev_load    = 1'b1;
              ev_press   = 1'b0;
              deb_next   = '0;
              col_next   = '0;
              state_next = IDLE;
            end else begin
              deb_next = deb_cnt + 4'd1;
            end
          end else begin
            deb_next   = '0;
            state_next = HELD;
          end
        end
        default: begin
          col_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    scan_state = state;
    if (state == IDLE) begin
      col_out = '1;
    end else begin
      col_out = COLS'(1) << col_idx;
    end
  end

  keypad_event_reg #(
    .CODE_W(CODE_W)
  ) u_event_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (ev_load),
    .load_code  (ev_code),
    .load_press (ev_press),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_valid  (key_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a 4x4 default instance (a) and a 2x8
// instance (b). Each has a switch-matrix model; expected events
// {multi, press, code} are queued by the stimulus and popped by a monitor on
// every completed handshake.
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance a: 4x4 ----------------
  logic [15:0] keys_a;
  logic [3:0]  row_a, col_a, code_a;
  logic        press_a, valid_a, ready_a, ovf_a, multi_a;
  logic [2:0]  state_a;

  always_comb begin
    row_a = '0;
    for (int r = 0; r < 4; r++) row_a[r] = |(keys_a[r*4 +: 4] & col_a);
  end

  keypad_matrix_scanner dut_a (
    .clock(clock), .reset(reset), .row_in(row_a), .col_out(col_a),
    .key_code(code_a), .key_press(press_a), .key_valid(valid_a),
    .key_ready(ready_a), .overflow(ovf_a), .multi_key(multi_a),
    .scan_state(state_a)
  );

  // ---------------- instance b: 2 rows x 8 columns ----------------
  logic [15:0] keys_b;
  logic [1:0]  row_b;
  logic [7:0]  col_b;
  logic [3:0]  code_b;
  logic        press_b, valid_b, ready_b, ovf_b, multi_b;
  logic [2:0]  state_b;

  always_comb begin
    row_b = '0;
    for (int r = 0; r < 2; r++) row_b[r] = |(keys_b[r*8 +: 8] & col_b);
  end

  keypad_matrix_scanner #(.ROWS(2), .COLS(8)) dut_b (
    .clock(clock), .reset(reset), .row_in(row_b), .col_out(col_b),
    .key_code(code_b), .key_press(press_b), .key_valid(valid_b),
    .key_ready(ready_b), .overflow(ovf_b), .multi_key(multi_b),
    .scan_state(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_a_q[$];
  logic [5:0] exp_b_q[$];
  logic [5:0] mon_a_e, mon_b_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && valid_a && ready_a) begin
      if (exp_a_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_event: got code %0d press %0b expected no event", code_a, press_a);
      end else begin
        mon_a_e = exp_a_q.pop_front();
        check("a_code", code_a, mon_a_e[3:0]);
        check("a_press", press_a, mon_a_e[4]);
        check("a_multi", multi_a, mon_a_e[5]);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && valid_b && ready_b) begin
      if (exp_b_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_event: got code %0d press %0b expected no event", code_b, press_b);
      end else begin
        mon_b_e = exp_b_q.pop_front();
        check("b_code", code_b, mon_b_e[3:0]);
        check("b_press", press_b, mon_b_e[4]);
        check("b_multi", multi_b, mon_b_e[5]);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input bit sel_b, input logic [2:0] s, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if ((sel_b ? state_b : state_a) == s) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: state %0d not reached in %0d cycles, now %0d", name, s, budget,
               sel_b ? state_b : state_a);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty(input bit sel_b, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if ((sel_b ? exp_b_q.size() : exp_a_q.size()) == 0) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles", name,
               sel_b ? exp_b_q.size() : exp_a_q.size(), budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    keys_a  = '0;
    keys_b  = '0;
    ready_a = 1'b1;
    ready_b = 1'b1;

    // Reset values.
    @(negedge clock);
    check("rst_col", col_a, 4'hf);
    check("rst_valid", valid_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_state", state_a, IDLE);
    check("rst_code", code_a, 4'd0);
    check("rst_multi", multi_a, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Key 11 (row 2, column 3): press then release.
    exp_a_q.push_back({1'b0, 1'b1, 4'd11});
    keys_a[11] = 1'b1;
    wait_state(1'b0, HELD, 200, "k11_held");
    check("k11_col", col_a, 4'b1000);
    wait_empty(1'b0, 20, "k11_press");
    exp_a_q.push_back({1'b0, 1'b0, 4'd11});
    keys_a[11] = 1'b0;
    wait_state(1'b0, IDLE, 200, "k11_idle");
    wait_empty(1'b0, 20, "k11_release");

    // Row 1 pulse lasting two samples in DEBOUNCE_P: no event.
    keys_a[4] = 1'b1;
    wait_state(1'b0, DEBOUNCE_P, 200, "glitch_debp");
    tick(16);
    keys_a[4] = 1'b0;
    wait_state(1'b0, IDLE, 100, "glitch_idle");
    tick(20);
    check("glitch_valid", valid_a, 1'b0);
    check("glitch_state", state_a, IDLE);

    // Rows 0 and 3 in column 1: lowest row wins, multi_key raised.
    exp_a_q.push_back({1'b1, 1'b1, 4'd1});
    keys_a[1]  = 1'b1;
    keys_a[13] = 1'b1;
    wait_state(1'b0, HELD, 200, "multi_held");
    check("multi_level", multi_a, 1'b1);
    wait_empty(1'b0, 20, "multi_press");
    exp_a_q.push_back({1'b0, 1'b0, 4'd1});
    keys_a[1]  = 1'b0;
    keys_a[13] = 1'b0;
    wait_state(1'b0, IDLE, 200, "multi_idle");
    wait_empty(1'b0, 20, "multi_release");

    // Consumer stalled: press of key 5 held, its release dropped.
    ready_a = 1'b0;
    exp_a_q.push_back({1'b0, 1'b1, 4'd5});
    keys_a[5] = 1'b1;
    wait_state(1'b0, HELD, 200, "ovf_held");
    tick(3);
    check("ovf_valid_press", valid_a, 1'b1);
    check("ovf_no_ovf_yet", ovf_a, 1'b0);
    keys_a[5] = 1'b0;
    wait_state(1'b0, IDLE, 200, "ovf_idle");
    tick(3);
    check("ovf_flag", ovf_a, 1'b1);
    check("ovf_valid_kept", valid_a, 1'b1);
    check("ovf_code_kept", code_a, 4'd5);
    check("ovf_press_kept", press_a, 1'b1);
    ready_a = 1'b1;
    wait_empty(1'b0, 20, "ovf_deliver");
    tick(3);
    check("ovf_drained", valid_a, 1'b0);
    check("ovf_sticky", ovf_a, 1'b1);

    // Reset while HELD with an event waiting.
    ready_a = 1'b0;
    keys_a[14] = 1'b1;
    wait_state(1'b0, HELD, 200, "rsth_held");
    tick(2);
    check("rsth_valid_before", valid_a, 1'b1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("rsth_valid", valid_a, 1'b0);
    check("rsth_col", col_a, 4'hf);
    check("rsth_state", state_a, IDLE);
    check("rsth_ovf", ovf_a, 1'b0);
    keys_a[14] = 1'b0;
    tick(2);
    reset   = 1'b0;
    ready_a = 1'b1;
    tick(30);
    check("rsth_stays_idle", state_a, IDLE);

    // 2x8 instance: row 1, column 7 -> code 15.
    exp_b_q.push_back({1'b0, 1'b1, 4'd15});
    keys_b[15] = 1'b1;
    wait_state(1'b1, HELD, 300, "b_held");
    check("b_col", col_b, 8'h80);
    wait_empty(1'b1, 20, "b_press");
    exp_b_q.push_back({1'b0, 1'b0, 4'd15});
    keys_b[15] = 1'b0;
    wait_state(1'b1, IDLE, 200, "b_idle");
    wait_empty(1'b1, 20, "b_release");
    check("b_ovf", ovf_b, 1'b0);

    tick(5);
    check("a_queue_left", exp_a_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
